// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: shared oversampling tick, TX framer, RX deframer.
// Runtime divisor, 5..DATA_W data bits, none/even/odd parity, 1 or 2 stop bits.
module uart_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OSR    = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic [3:0]        data_len,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);

  localparam int unsigned     TickW    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(OSR - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(OSR / 2 - 1);
  localparam logic [3:0]       LenMax   = 4'(DATA_W);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Tick generator
  logic [DIV_W-1:0] tick_cnt_q;
  logic             tick;

  assign tick = (tick_cnt_q >= div);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + DIV_W'(1);
    end
  end

  // Configuration decode shared by both directions
  logic [3:0]        eff_len;
  logic              par_en;
  logic [DATA_W-1:0] len_mask;
  logic              tx_par_bit;

  always_comb begin
    eff_len    = ((data_len >= 4'd5) && (data_len <= LenMax)) ? data_len : LenMax;
    par_en     = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    len_mask   = {DATA_W{1'b1}} >> (LenMax - eff_len);
    tx_par_bit = (^(tx_data & len_mask)) ^ (parity_mode == 2'b10);
  end

  // TX framer
  tx_state_e         tx_state_q;
  logic [TickW-1:0]  tx_tick_q;
  logic [3:0]        tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [3:0]        tx_len_q;
  logic              tx_par_en_q;
  logic              tx_stop2_q;
  logic              tx_par_q;
  logic              txd_q;
  logic              tx_ready_q;
  logic              tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == TickLast);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      tx_state_q  <= TxIdle;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_len_q    <= LenMax;
      tx_par_en_q <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_par_q    <= 1'b0;
      txd_q       <= 1'b1;
      tx_ready_q  <= 1'b1;
    end else begin
      if (tick && (tx_state_q != TxIdle)) begin
        tx_tick_q <= (tx_tick_q == TickLast) ? '0 : tx_tick_q + TickW'(1);
      end
      case (tx_state_q)
        TxIdle: begin
          if (tx_valid && tx_ready_q) begin
            tx_state_q  <= TxStart;
            tx_ready_q  <= 1'b0;
            txd_q       <= 1'b0;
            tx_tick_q   <= '0;
            tx_shift_q  <= tx_data;
            tx_len_q    <= eff_len;
            tx_par_en_q <= par_en;
            tx_stop2_q  <= stop_bits;
            tx_par_q    <= tx_par_bit;
          end
        end
        TxStart: begin
          if (tx_bit_end) begin
            tx_state_q <= TxData;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end
        TxData: begin
          if (tx_bit_end) begin
            if (tx_bit_q == tx_len_q - 4'd1) begin
              if (tx_par_en_q) begin
                tx_state_q <= TxParity;
                txd_q      <= tx_par_q;
              end else begin
                tx_state_q <= TxStop;
                txd_q      <= 1'b1;
                tx_bit_q   <= '0;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
        end
        TxParity: begin
          if (tx_bit_end) begin
            tx_state_q <= TxStop;
            txd_q      <= 1'b1;
            tx_bit_q   <= '0;
          end
        end
        TxStop: begin
          if (tx_bit_end) begin
            if (tx_stop2_q && (tx_bit_q == 4'd0)) begin
              tx_bit_q <= 4'd1;
            end else begin
              tx_state_q <= TxIdle;
              tx_ready_q <= 1'b1;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = tx_ready_q;

  // RX synchroniser; idles high so reset never looks like a start bit
  logic rxd_meta_q;
  logic rxd_sync_q;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // RX deframer
  rx_state_e         rx_state_q;
  logic [TickW-1:0]  rx_tick_q;
  logic [3:0]        rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [3:0]        rx_len_q;
  logic              rx_par_en_q;
  logic              rx_odd_q;
  logic              rx_stop2_q;
  logic              rx_par_acc_q;
  logic              rx_perr_q;
  logic              rx_ferr_q;
  logic              rx_bit_end;
  logic              rx_load;

  assign rx_bit_end = tick && (rx_tick_q == TickLast);
  assign rx_load    = (rx_state_q == RxStop) && rx_bit_end &&
                      !(rx_stop2_q && (rx_bit_q == 4'd0));

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rx_state_q   <= RxIdle;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_len_q     <= LenMax;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_stop2_q   <= 1'b0;
      rx_par_acc_q <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      if (tick && (rx_state_q != RxIdle)) begin
        rx_tick_q <= (rx_tick_q == TickLast) ? '0 : rx_tick_q + TickW'(1);
      end
      case (rx_state_q)
        RxIdle: begin
          if (tick && !rxd_sync_q) begin
            rx_state_q  <= RxStart;
            rx_tick_q   <= '0;
            rx_len_q    <= eff_len;
            rx_par_en_q <= par_en;
            rx_odd_q    <= (parity_mode == 2'b10);
            rx_stop2_q  <= stop_bits;
          end
        end
        RxStart: begin
          if (tick && (rx_tick_q == TickHalf)) begin
            rx_tick_q <= '0;
            if (rxd_sync_q) begin
              rx_state_q <= RxIdle;
            end else begin
              rx_state_q   <= RxData;
              rx_bit_q     <= '0;
              rx_shift_q   <= '0;
              rx_par_acc_q <= 1'b0;
              rx_perr_q    <= 1'b0;
              rx_ferr_q    <= 1'b0;
            end
          end
        end
        RxData: begin
          if (rx_bit_end) begin
            // Shift in from the top; right-justified when loaded out
            rx_shift_q   <= {rxd_sync_q, rx_shift_q[DATA_W-1:1]};
            rx_par_acc_q <= rx_par_acc_q ^ rxd_sync_q;
            if (rx_bit_q == rx_len_q - 4'd1) begin
              rx_bit_q   <= '0;
              rx_state_q <= rx_par_en_q ? RxParity : RxStop;
            end else begin
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end
        end
        RxParity: begin
          if (rx_bit_end) begin
            rx_perr_q  <= rx_par_acc_q ^ rxd_sync_q ^ rx_odd_q;
            rx_state_q <= RxStop;
          end
        end
        RxStop: begin
          if (rx_bit_end) begin
            if (!rxd_sync_q) begin
              rx_ferr_q <= 1'b1;
            end
            if (rx_stop2_q && (rx_bit_q == 4'd0)) begin
              rx_bit_q <= 4'd1;
            end else begin
              rx_state_q <= RxIdle;
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Output registers; a load in the handshake cycle wins over the clear
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_perr_out_q;
  logic              rx_ferr_out_q;
  logic              rx_ovr_q;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_out_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else if (rx_load) begin
      rx_data_q     <= rx_shift_q >> (LenMax - rx_len_q);
      rx_valid_q    <= 1'b1;
      rx_perr_out_q <= rx_perr_q;
      rx_ferr_out_q <= rx_ferr_q | !rxd_sync_q;
      rx_ovr_q      <= rx_valid_q && !rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_out_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_out_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: loopback and driven-rxd frames, with a
// scoreboard queue of expected received words.
module tb_uart_core_param;

  localparam int DATA_W = 8;
  localparam int OSR    = 16;
  localparam int DIV_W  = 16;

  logic              clk_50M = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  div;
  logic [3:0]        data_len;
  logic [1:0]        parity_mode;
  logic              stop_bits;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              txd;
  logic              rxd;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;

  logic loop_en = 1'b1;
  logic rxd_drv = 1'b1;
  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk_50M = ~clk_50M;

  uart_core_param #(
    .DATA_W(DATA_W),
    .OSR   (OSR),
    .DIV_W (DIV_W)
  ) dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .div          (div),
    .data_len     (data_len),
    .parity_mode  (parity_mode),
    .stop_bits    (stop_bits),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .txd          (txd),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  int unsigned cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int bit_cyc;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       ov;
  } rx_exp_t;

  rx_exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Reference frame: bit 0 is the start bit, then data LSB first, parity, stops
  function automatic int build_frame(input logic [7:0] d, input int len, input logic [1:0] pm,
                                     input logic s2, input logic flip_par,
                                     output logic [15:0] f);
    int   n;
    logic p;
    n = 0;
    p = 1'b0;
    f = '1;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < len; i++) begin
      f[n] = d[i];
      p    = p ^ d[i];
      n++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      f[n] = p ^ (pm == 2'b10) ^ flip_par;
      n++;
    end
    f[n] = 1'b1;
    n++;
    if (s2) begin
      f[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic expect_rx(input string tag);
    rx_exp_t e;
    rx_exp_t o;
    int      k;
    k = 0;
    @(negedge clk_50M);
    while (!rx_valid && k < 3000) begin
      @(negedge clk_50M);
      k++;
    end
    check({tag, "_valid"}, rx_valid, 1);
    if (rx_valid && sb.size() > 0) begin
      e = sb.pop_front();
      o = {rx_data, rx_parity_err, rx_frame_err, rx_overrun};
      check({tag, "_word"}, o, e);
      rx_ready = 1'b1;
      @(posedge clk_50M);
      #1 rx_ready = 1'b0;
      @(negedge clk_50M);
      check({tag, "_clear"}, rx_valid, 0);
    end else if (sb.size() > 0) begin
      sb.delete(0);
    end
  endtask

  task automatic send_tx(input logic [7:0] d, output int unsigned t0);
    int k;
    k = 0;
    while (!tx_ready && k < 1000) begin
      @(negedge clk_50M);
      k++;
    end
    check("tx_ready_idle", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk_50M);
    #1 t0 = cyc;
    tx_valid = 1'b0;
    @(negedge clk_50M);
    check("tx_ready_drop", tx_ready, 0);
  endtask

  // Loopback frame: check the txd waveform at bit centres, the frame length and the word received
  task automatic tx_frame(input string tag, input logic [7:0] d);
    logic [15:0] ef;
    logic [15:0] of;
    int          n;
    int          k;
    int unsigned t0;
    int unsigned dt;
    rx_exp_t     e;
    n = build_frame(d, int'(data_len), parity_mode, stop_bits, 1'b0, ef);
    send_tx(d, t0);
    of = '1;
    repeat (bit_cyc / 2 - 1) @(negedge clk_50M);
    for (int i = 0; i < n; i++) begin
      of[i] = txd;
      if (i < n - 1) repeat (bit_cyc) @(negedge clk_50M);
    end
    check({tag, "_wave"}, of, ef);
    k = 0;
    while (!tx_ready && k < 2000) begin
      @(negedge clk_50M);
      k++;
    end
    dt = cyc - t0;
    // First bit can be up to one tick period short depending on tick phase
    check({tag, "_len"}, (dt >= n * bit_cyc - int'(div)) && (dt <= n * bit_cyc), 1);
    e.data = d & (8'hFF >> (8 - int'(data_len)));
    e.pe   = 1'b0;
    e.fe   = 1'b0;
    e.ov   = 1'b0;
    sb.push_back(e);
    expect_rx({tag, "_rx"});
  endtask

  // Drive a frame on rxd; a bad stop is held low for 3/4 of its bit time only
  task automatic drive_frame(input logic [15:0] f, input int n, input bit bad_stop);
    @(posedge clk_50M);
    #1;
    for (int i = 0; i < n; i++) begin
      rxd_drv = (bad_stop && i == n - 1) ? 1'b0 : f[i];
      if (bad_stop && i == n - 1) begin
        repeat (bit_cyc * 3 / 4) @(posedge clk_50M);
        #1 rxd_drv = 1'b1;
        repeat (bit_cyc / 4) @(posedge clk_50M);
        #1;
      end else begin
        repeat (bit_cyc) @(posedge clk_50M);
        #1;
      end
    end
    rxd_drv = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    rx_exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    e.ov   = ov;
    sb.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  f;
    int           n;
    int unsigned  t0;

    reset       = 1'b1;
    div         = 16'd1;
    data_len    = 4'd8;
    parity_mode = 2'b00;
    stop_bits   = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    bit_cyc     = OSR * (int'(div) + 1);

    repeat (3) @(negedge clk_50M);
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk_50M);

    // 1: loopback 8N1
    tx_frame("t1", 8'hA5);

    // 2: 7 bits, even then odd parity, two stops; bit 7 of tx_data must be ignored
    data_len    = 4'd7;
    parity_mode = 2'b01;
    stop_bits   = 1'b1;
    tx_frame("t2_even", 8'h53);
    parity_mode = 2'b10;
    tx_frame("t2_odd", 8'hD3);

    // 3: driven frames, odd parity with wrong parity bit, then a low stop bit
    loop_en     = 1'b0;
    data_len    = 4'd8;
    parity_mode = 2'b10;
    stop_bits   = 1'b0;
    n = build_frame(8'h0F, 8, 2'b10, 1'b0, 1'b1, f);
    push_exp(8'h0F, 1'b1, 1'b0, 1'b0);
    drive_frame(f, n, 1'b0);
    repeat (40) @(posedge clk_50M);
    expect_rx("t3_par");
    n = build_frame(8'h0F, 8, 2'b10, 1'b0, 1'b0, f);
    push_exp(8'h0F, 1'b0, 1'b1, 1'b0);
    drive_frame(f, n, 1'b1);
    repeat (60) @(posedge clk_50M);
    expect_rx("t3_stop");

    // 4: glitch of 4 ticks is a false start, then a clean frame
    parity_mode = 2'b00;
    repeat (40) @(posedge clk_50M);
    #1 rxd_drv = 1'b0;
    repeat (2 * (int'(div) + 1)) @(posedge clk_50M);
    repeat (2 * (int'(div) + 1)) @(posedge clk_50M);
    #1 rxd_drv = 1'b1;
    repeat (60) @(negedge clk_50M);
    check("t4_no_valid", rx_valid, 0);
    n = build_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, f);
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    drive_frame(f, n, 1'b0);
    repeat (20) @(posedge clk_50M);
    expect_rx("t4");

    // 5: overrun, then a clean word after the handshake
    n = build_frame(8'h11, 8, 2'b00, 1'b0, 1'b0, f);
    drive_frame(f, n, 1'b0);
    n = build_frame(8'h22, 8, 2'b00, 1'b0, 1'b0, f);
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    drive_frame(f, n, 1'b0);
    repeat (20) @(posedge clk_50M);
    expect_rx("t5_ovr");
    n = build_frame(8'h5A, 8, 2'b00, 1'b0, 1'b0, f);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    drive_frame(f, n, 1'b0);
    repeat (20) @(posedge clk_50M);
    expect_rx("t5_next");

    // 6: reset in the middle of a TX data phase, then an immediate new frame
    loop_en = 1'b1;
    repeat (40) @(negedge clk_50M);
    send_tx(8'hC3, t0);
    repeat (100) @(negedge clk_50M);
    reset = 1'b1;
    @(negedge clk_50M);
    check("t6_txd", txd, 1);
    check("t6_tx_ready", tx_ready, 1);
    check("t6_rx_valid", rx_valid, 0);
    reset = 1'b0;
    tx_frame("t6", 8'h3A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART transceiver: one shared oversampling tick generator, one TX framer and one RX deframer.
- Generalises the fixed 7/8-bit, fixed-rate UART to a runtime divisor, 5..DATA_W data bits, none/even/odd parity and 1/2 stop bits.
- Adds valid/ready handshakes on both data paths, plus parity, framing and overrun reporting.
- Sits between the host logic and the serial pins, all on clk_50M.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9).
OSR, 16, oversampling ticks per bit (even, >=4).
DIV_W, 16, width of the divisor input.

Ports:
clk_50M  in  1  system clock
reset  in  1  synchronous, active-high reset
div  in  DIV_W  tick period = div+1 clk_50M cycles; one bit = OSR ticks
data_len  in  4  data bits per frame; values outside 5..DATA_W are treated as DATA_W
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop_bits  in  1  0 = one stop bit, 1 = two stop bits
tx_data  in  DATA_W  byte to send, LSB first; bits above data_len are ignored
tx_valid  in  1  TX request
tx_ready  out  1  TX can accept
txd  out  1  serial output, idle high
rxd  in  1  serial input, asynchronous
rx_data  out  DATA_W  received word, right-justified, upper bits 0
rx_valid  out  1  rx_data and flags valid
rx_ready  in  1  consumer accepts
rx_parity_err  out  1  parity mismatch on the presented word
rx_frame_err  out  1  a stop bit was sampled 0
rx_overrun  out  1  at least one previous word was overwritten

Behaviour:
Reset (synchronous, active-high):
- Values: txd=1, tx_ready=1, rx_valid=0, all error flags 0, rx_data=0.
- Tick counter=0, both FSMs in IDLE, synchroniser flops=1.
- Asserting reset mid-frame aborts the frame: txd is 1 at the next edge and any partial RX word is discarded.

Tick generator:
- Counter increments each cycle; when counter>=div, it emits a 1-cycle tick and clears.
- div=0 gives a tick every cycle.
- Changing div mid-frame corrupts that frame only; the block never locks up.

Configuration latching:
- data_len, parity_mode and stop_bits are latched at TX accept and at RX start detect.
- Later changes do not affect the frame in flight.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- tx_ready=1 only in IDLE; accept when tx_valid && tx_ready; tx_ready drops the next cycle.
- txd=0 from the cycle after accept; each bit is held for exactly OSR ticks.
- DATA: data_len bits, LSB first.
- PARITY: only if parity_mode is 01 or 10. Bit value = XOR of the data bits for even, inverted XOR for odd.
- STOP: txd=1 for 1 or 2 bit times, then IDLE with tx_ready=1.
- Back-to-back frames are allowed: tx_valid held high gives no extra idle bit.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- rxd passes through a 2-flop synchroniser; all samples are taken on ticks.
- IDLE: on a tick with rxd_sync=0, go to START.
- START: count OSR/2 ticks and resample. If 1, it is a false start: return to IDLE with no output. If 0, go to DATA.
- Data and parity bits are sampled every OSR ticks (bit centre), LSB first into the shift register.
- Each stop bit is sampled at its centre; any 0 sets the frame error for this word.
- After the last stop-bit sample, the block loads the output registers and returns to IDLE in the same cycle, so the next start edge is detectable at once.

Output registers:
- Load sets rx_data, rx_parity_err and rx_frame_err, and sets rx_valid=1.
- If rx_valid was already 1 and not consumed in the load cycle, rx_overrun=1. Otherwise rx_overrun=0.
- rx_valid and the flags hold until rx_valid && rx_ready; rx_valid then clears the next cycle.
- If a load coincides with a handshake, the new word wins: rx_valid stays 1 and no overrun is flagged.
- Words with errors are still delivered, with their flags set.
- RX never stalls; TX and RX operate independently.

Test Plan:
1. Loopback txd->rxd, div=1, data_len=8, parity=00, stop=0, tx_data=0xA5. Required: txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 32 cycles; tx_ready back high 320 cycles after accept; rx_valid with 0xA5 and no flags.
2. Loopback, data_len=7, even parity, 2 stop bits, tx_data=0x53. Required: parity bit 0, frame 11 bits; rx_data=0x53, rx_parity_err=0; odd parity instead gives parity bit 1 with the same data.
3. Driven rxd frame, data 0x0F, data_len=8, odd parity with parity bit 0. Required: rx_data=0x0F, rx_parity_err=1; stop bit driven 0 gives rx_frame_err=1.
4. rxd low for 4 ticks (8 cycles at div=1), then high. Required: no rx_valid; a following valid 0x3C frame is received correctly.
5. Two frames 0x11 then 0x22 with rx_ready=0. Required: rx_data=0x22, rx_overrun=1; after the handshake rx_valid=0 and rx_overrun=0 on the next word.
6. Reset asserted mid-DATA of a TX frame. Required: txd=1 and tx_ready=1 at the next edge; a new tx_valid is accepted immediately and sent correctly.
